// File: rtl/hs_sync_rx_pkg.sv
// Shared types and constants for the toggle-handshake receiver.
package hs_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/hs_sync_rx_if.sv
// Source-side toggle/data signals and destination-side valid/ready bus of hs_sync_rx.
interface hs_sync_rx_if #(
  parameter int WIDTH = 8
);
  logic             req_tgl_a;
  logic [WIDTH-1:0] data_a;
  logic             ack_tgl;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             ready;

  // master: the environment driving requests and consuming words
  modport master (
    output req_tgl_a, data_a, ready,
    input  ack_tgl, data_out, valid
  );

  // slave: the receiver
  modport slave (
    input  req_tgl_a, data_a, ready,
    output ack_tgl, data_out, valid
  );
endinterface

// File: rtl/hs_sync_rx_sync_ff_chain.sv
// 1-bit synchroniser flop chain with synchronous active-high reset to RST_VAL.
module sync_ff_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d    = chain_q << 1;
    chain_d[0] = d;
  end

  always_ff @(posedge clk) begin
    if (rst) chain_q <= {STAGES{RST_VAL}};
    else     chain_q <= chain_d;
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/hs_sync_rx.sv
// Destination-side receiver of a toggle-handshake bus synchroniser with sticky protocol error.
// Optional transfer counter output xfer_cnt enabled by macro HS_SYNC_RX_XFER_CNT_EN.
module hs_sync_rx
  import hs_sync_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  hs_sync_rx_if.slave      bus,
  output logic             err
`ifdef HS_SYNC_RX_XFER_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  if (STAGES < SYNC_STAGES_MIN) begin : g_stages_chk
    $error("hs_sync_rx: STAGES=%0d below minimum %0d", STAGES, SYNC_STAGES_MIN);
  end
  if (CNT_W < 1) begin : g_cnt_chk
    $error("hs_sync_rx: CNT_W must be at least 1");
  end

  state_e           state_q, state_d;
  logic             req_s;
  logic             req_seen_q, req_seen_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             edge_det;
  logic             handover;

  sync_ff_chain #(
    .STAGES  (STAGES),
    .RST_VAL (1'b0)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.req_tgl_a),
    .q   (req_s)
  );

  // A pending request is any mismatch between the synchronised level and the last one taken.
  assign edge_det = req_s ^ req_seen_q;
  assign handover = (state_q == HOLD) && bus.ready && ena;

  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ack_d      = ack_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (edge_det && ena) begin
          data_d     = bus.data_a;
          req_seen_d = req_s;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // A second toggle before ack is flagged but never consumed here.
        if (edge_det) err_d = 1'b1;
        if (handover) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_seen_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.ack_tgl  = ack_q;
  assign err          = err_q;

`ifdef HS_SYNC_RX_XFER_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (handover) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_hs_sync_rx.sv
// Bench for hs_sync_rx: STAGES=2 and STAGES=3 instances share stimulus and are checked each cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_hs_sync_rx;

  localparam int W     = 8;
  localparam int CNT_W = 8;
  localparam int NI    = 2;

  logic         clk = 1'b0;
  logic         rst, ena, req, ready;
  logic [W-1:0] din;
  logic         err2, err3;
`ifdef HS_SYNC_RX_XFER_CNT_EN
  logic [CNT_W-1:0] cnt2, cnt3;
`endif

  hs_sync_rx_if #(.WIDTH(W)) if2 ();
  hs_sync_rx_if #(.WIDTH(W)) if3 ();

  assign if2.req_tgl_a = req;
  assign if2.data_a    = din;
  assign if2.ready     = ready;
  assign if3.req_tgl_a = req;
  assign if3.data_a    = din;
  assign if3.ready     = ready;

  hs_sync_rx #(.WIDTH(W), .STAGES(2), .CNT_W(CNT_W)) dut2 (
    .clk (clk), .rst (rst), .ena (ena), .bus (if2), .err (err2)
`ifdef HS_SYNC_RX_XFER_CNT_EN
    , .xfer_cnt (cnt2)
`endif
  );

  hs_sync_rx #(.WIDTH(W), .STAGES(3), .CNT_W(CNT_W)) dut3 (
    .clk (clk), .rst (rst), .ena (ena), .bus (if3), .err (err3)
`ifdef HS_SYNC_RX_XFER_CNT_EN
    , .xfer_cnt (cnt3)
`endif
  );

  always #5 clk = ~clk;

  // Outputs gathered per instance (0: STAGES=2, 1: STAGES=3)
  logic         o_valid [NI];
  logic         o_ack   [NI];
  logic         o_err   [NI];
  logic [W-1:0] o_data  [NI];
  assign o_valid[0] = if2.valid;    assign o_valid[1] = if3.valid;
  assign o_ack[0]   = if2.ack_tgl;  assign o_ack[1]   = if3.ack_tgl;
  assign o_err[0]   = err2;         assign o_err[1]   = err3;
  assign o_data[0]  = if2.data_out; assign o_data[1]  = if3.data_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Transaction-level model: the receiver sees the request level as it was S edges ago,
  // takes one word per observed level change, and returns one ack per consumed word.
  bit         m_hist  [NI][4];
  bit         m_seen  [NI];
  bit         m_busy  [NI];
  bit         m_valid [NI];
  bit [W-1:0] m_data  [NI];
  bit         m_ack   [NI];
  bit         m_err   [NI];
  int         m_acks  [NI];
  bit [CNT_W-1:0] m_cnt [NI];

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      int s;
      bit seen_lvl;
      s = (k == 0) ? 2 : 3;
      seen_lvl = m_hist[k][s-1];
      if (rst) begin
        for (int i = 0; i < 4; i++) m_hist[k][i] = 1'b0;
        m_seen[k] = 0; m_busy[k] = 0; m_valid[k] = 0; m_data[k] = '0;
        m_ack[k] = 0; m_err[k] = 0; m_acks[k] = 0; m_cnt[k] = '0;
      end else begin
        if (!m_busy[k]) begin
          if (seen_lvl != m_seen[k] && ena) begin
            m_data[k] = din; m_seen[k] = seen_lvl; m_valid[k] = 1; m_busy[k] = 1;
          end
        end else begin
          if (seen_lvl != m_seen[k]) m_err[k] = 1;
          if (ready && ena) begin
            m_valid[k] = 0; m_busy[k] = 0; m_ack[k] = ~m_ack[k];
            m_acks[k]++; m_cnt[k] = m_cnt[k] + 1'b1;
          end
        end
        for (int i = 3; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
        m_hist[k][0] = req;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("valid[%0d]", k), 32'(o_valid[k]), 32'(m_valid[k]));
        chk($sformatf("ack[%0d]", k),   32'(o_ack[k]),   32'(m_ack[k]));
        chk($sformatf("err[%0d]", k),   32'(o_err[k]),   32'(m_err[k]));
        chk($sformatf("data[%0d]", k),  32'(o_data[k]),  32'(m_data[k]));
      end
`ifdef HS_SYNC_RX_XFER_CNT_EN
      chk("cnt[0]", 32'(cnt2), 32'(m_cnt[0]));
      chk("cnt[1]", 32'(cnt3), 32'(m_cnt[1]));
`endif
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    rst = 1'b1; ena = 1'b1; req = 1'b0; ready = 1'b0; din = '0;

    // Reset
    tick(2);
    chk("rst_valid", 32'(if2.valid), 0);
    chk("rst_data",  32'(if2.data_out), 0);
    chk("rst_ack",   32'(if2.ack_tgl), 0);
    chk("rst_err",   32'(err2), 0);
    chk_en = 1'b1;
    rst = 1'b0;
    tick(4);
    chk("rst_release_valid", 32'(if2.valid), 0);

    // Single transfer with ready held high
    din = 8'hA5; req = 1'b1; ready = 1'b1;
    tick(2);
    chk("lat_e2_valid", 32'(if2.valid), 0);
    tick(1);
    chk("lat_e3_valid", 32'(if2.valid), 1);
    chk("lat_e3_data",  32'(if2.data_out), 32'h A5);
    chk("lat_e3_ack",   32'(if2.ack_tgl), 0);
    chk("lat_e3_s3_valid", 32'(if3.valid), 0);
    chk("model_lat_e3", 32'(m_valid[0]), 1);
    tick(1);
    chk("lat_e4_valid", 32'(if2.valid), 0);
    chk("lat_e4_ack",   32'(if2.ack_tgl), 1);
    chk("lat_e4_s3_valid", 32'(if3.valid), 1);
    tick(1);
    chk("lat_e5_s3_ack", 32'(if3.ack_tgl), 1);
    tick(3);

    // Backpressure: word frozen while ready is low
    din = 8'hA5; req = 1'b0; ready = 1'b0;
    tick(4);
    chk("bp_valid2", 32'(if2.valid), 1);
    chk("bp_valid3", 32'(if3.valid), 1);
    din = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bp_hold_valid", 32'(if2.valid), 1);
      chk("bp_hold_data",  32'(if2.data_out), 32'h A5);
      chk("bp_hold_ack",   32'(if2.ack_tgl), 1);
    end
    ready = 1'b1;
    tick(1);
    chk("bp_rel_valid", 32'(if2.valid), 0);
    chk("bp_rel_ack",   32'(if2.ack_tgl), 0);
    chk("bp_rel_ack3",  32'(if3.ack_tgl), 0);
    tick(2);

    // Enable gating: request stays pending while ena is low
    ena = 1'b0; din = 8'h5A; req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("ena_gate_valid2", 32'(if2.valid), 0);
      chk("ena_gate_valid3", 32'(if3.valid), 0);
    end
    ena = 1'b1;
    tick(1);
    chk("ena_rise_valid2", 32'(if2.valid), 1);
    chk("ena_rise_data2",  32'(if2.data_out), 32'h 5A);
    chk("ena_rise_valid3", 32'(if3.valid), 1);
    tick(1);
    chk("ena_done_ack2", 32'(if2.ack_tgl), 1);
    tick(2);

    // Protocol violation: double toggle while a word is held
    ready = 1'b0; din = 8'hC3; req = 1'b0;
    tick(5);
    chk("pv_pre_err", 32'(err3), 0);
    req = 1'b1;
    tick(1);
    req = 1'b0;
    tick(5);
    chk("pv_err2",   32'(err2), 1);
    chk("pv_err3",   32'(err3), 1);
    chk("pv_data2",  32'(if2.data_out), 32'h C3);
    chk("pv_valid3", 32'(if3.valid), 1);
    ready = 1'b1;
    tick(1);
    chk("pv_ho_valid", 32'(if2.valid), 0);
    chk("pv_ho_ack",   32'(if2.ack_tgl), 0);
    chk("pv_ho_err",   32'(err2), 1);
    tick(4);
    chk("pv_after_err",   32'(err2), 1);
    chk("pv_after_valid", 32'(if3.valid), 0);
    chk("pv_after_data",  32'(if3.data_out), 32'h C3);

    // Reset in the middle of a held transfer
    ready = 1'b0; din = 8'h99; req = 1'b1;
    tick(4);
    chk("mid_pre_valid3", 32'(if3.valid), 1);
    rst = 1'b1; req = 1'b0;
    tick(1);
    chk("mid_rst_valid", 32'(if3.valid), 0);
    chk("mid_rst_err",   32'(err3), 0);
    chk("mid_rst_ack",   32'(if2.ack_tgl), 0);
    chk("mid_rst_data",  32'(if2.data_out), 0);
    rst = 1'b0;
    tick(6);
    chk("mid_after_valid", 32'(if2.valid), 0);

    // 256 back-to-back transfers
    ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      din = 8'(i); req = ~req;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        tick(1);
        done = (if2.ack_tgl == req) && (if3.ack_tgl == req);
      end
      chk("xfer_done", 32'(done), 1);
    end
    tick(1);
    chk("b2b_model_acks2", 32'(m_acks[0]), 256);
    chk("b2b_model_acks3", 32'(m_acks[1]), 256);
    chk("b2b_ack2", 32'(if2.ack_tgl), 0);
    chk("b2b_ack3", 32'(if3.ack_tgl), 0);
    chk("b2b_last_data", 32'(if3.data_out), 32'h FF);
`ifdef HS_SYNC_RX_XFER_CNT_EN
    chk("b2b_cnt2", 32'(cnt2), 0);
    chk("b2b_cnt3", 32'(cnt3), 0);
`endif

    // Randomised traffic with occasional rogue toggles and resets
    rst = 1'b1; req = 1'b0;
    tick(1);
    rst = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      ena   = ($urandom_range(0, 3) != 0);
      ready = ($urandom_range(0, 4) < 3);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; req = 1'b0;
      end else begin
        rst = 1'b0;
        if (if2.ack_tgl == req && if3.ack_tgl == req && $urandom_range(0, 2) == 0) begin
          din = 8'($urandom); req = ~req;
        end else if ($urandom_range(0, 49) == 0) begin
          req = ~req;
        end
      end
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hs_sync_rx.md
Name: hs_sync_rx

Overview:
- Destination-domain receiver for a toggle-handshake multi-bit bus synchroniser, running on a single clock `clk`.
- Inputs from the source domain:
  - `req_tgl_a`, a request toggle, synchronised through a parametrised flop chain.
  - `data_a`, a bus held stable by the source until acknowledged. It is captured once the synchronised request edge is seen.
- Outputs to the destination domain: the captured word, presented on a valid/ready interface.
- Output to the source domain: an acknowledge toggle.
- Successor to the fixed 8-bit two-flop/pulse synchronisers: adds width/depth parameters, backpressure, an acknowledge return path and protocol-error detection.

Parameters:
- WIDTH, 8: data bus width.
- STAGES, 2: depth of the request synchroniser chain, minimum 2.
- CNT_W, 8: width of the transfer counter. Used only with the optional feature.

Ports:
- clk  input  1  destination-domain clock.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  gates capture and acknowledge. The synchroniser chain keeps running when ena=0.
- req_tgl_a  input  1  asynchronous request toggle from the source domain.
- data_a  input  WIDTH  asynchronous data. The source holds it stable from its req toggle until it sees ack.
- ready  input  1  downstream accepts data_out.
- data_out  output  WIDTH  captured word.
- valid  output  1  data_out holds an unconsumed word.
- ack_tgl  output  1  acknowledge toggle returned to the source domain.
- err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1 at a clk edge), applied at any time including mid-transfer:
  - Synchroniser chain, req_seen, data_out, valid, ack_tgl and err all go to 0.
  - FSM goes to IDLE.
  - The source shares this reset. A req_tgl_a level of 1 seen after reset is treated as a new request.
- Synchroniser:
  - STAGES flops in series; req_s is the last stage.
  - edge = (req_s != req_seen), computed combinationally.
- FSM states: IDLE, HOLD.
- IDLE:
  - If edge && ena: data_out <= data_a, req_seen <= req_s, valid <= 1, go to HOLD.
  - Otherwise hold. An edge seen while ena=0 stays pending, because req_seen is unchanged.
- HOLD:
  - valid=1; data_out is frozen regardless of data_a.
  - If ready && ena: valid <= 0, ack_tgl <= ~ack_tgl, go to IDLE.
- Latency:
  - valid rises STAGES+1 rising edges after the edge that first samples the new req level (3 edges for STAGES=2).
  - ack_tgl toggles on the first edge at which valid && ready && ena.
- Simultaneous valid and ready:
  - The handover completes in that cycle, so valid can be high for a single cycle.
  - A new capture can occur no earlier than the next cycle in IDLE.
- Protocol error:
  - edge observed while in HOLD sets err=1 (the source toggled again before ack).
  - req_seen, data_out and valid are unaffected.
  - err clears only on rst.
- Invariants: data_out changes only on a capture; ack_tgl toggles exactly once per accepted word.

Optional Feature:
- Macro HS_SYNC_RX_XFER_CNT_EN.
- Defined:
  - Adds output port xfer_cnt [CNT_W-1:0], reset to 0.
  - Increments on every handover (valid && ready && ena in HOLD).
  - Wraps modulo 2^CNT_W.
- Undefined: the port and its logic are absent, and CNT_W is unused.

Decomposition:
- Package hs_sync_pkg contains:
  - The state enum {IDLE, HOLD}.
  - Constant SYNC_STAGES_MIN=2.
- The parameter is checked against SYNC_STAGES_MIN at elaboration.
- One sub-module, sync_ff_chain:
  - Parameters STAGES and RST_VAL.
  - 1-bit, synchronous active-high reset.
  - Instantiated for the request path and reusable elsewhere.

Test Plan:
1. Reset: rst=1 for 2 cycles with req_tgl_a=0 → data_out=0, valid=0, ack_tgl=0, err=0. Releasing rst produces no valid.
2. Single transfer, STAGES=2, ready=1:
   - Stimulus: data_a=8'hA5, req_tgl_a 0→1.
   - Response: valid=1 with data_out=8'hA5 on the 3rd edge; valid high for exactly 1 cycle; ack_tgl 0→1 on the following edge.
3. Backpressure:
   - Stimulus: as in scenario 2 but ready=0 for 10 cycles; data_a changes to 8'h3C after capture.
   - Response: valid stays 1, data_out stays 8'hA5, ack_tgl stays 0.
   - Then ready=1 → ack_tgl=1 and valid=0 on the next edge.
4. Enable gating: toggle req with ena=0 for 6 cycles → valid stays 0. Raising ena=1 → valid=1 on the next edge.
5. Protocol violation: while in HOLD, toggle req_tgl_a twice → err=1 and stays 1 after the handover completes; data_out is unchanged.
6. STAGES=3 with HS_SYNC_RX_XFER_CNT_EN, CNT_W=8:
   - Valid latency measures 4 edges.
   - 256 back-to-back handshaked transfers → xfer_cnt returns to 0; ack_tgl has toggled 256 times.
